// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and the central hazard controller.
// The master side is the datapath; the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, mem_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: EX forwarding selects, stall/flush arbitration,
// data-memory wait tracking with sticky timeout flag, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_cnt_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic w_mem_stall;
    logic w_lw_stall;
    logic w_flush_branch;

    // M-stage result wins over W because it is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        else                                         return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

    assign w_mem_stall    = hz.MemReqM && !hz.MemReadyM;
    assign w_lw_stall     = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                            ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign w_flush_branch = hz.PCSrcE && !w_mem_stall;

    // A memory wait freezes F..M, so any branch or load-use in E/D is simply replayed later.
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (w_mem_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (w_lw_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = WC_W'(1);
                end
            end
            S_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt != WC_W'(TIMEOUT)) w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end else begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
        // In RUN the count is 0, so TIMEOUT==1 flags on the very first stall cycle.
        if (w_mem_stall && r_wait_cnt == WC_W'(TIMEOUT - 1)) w_mem_err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
            if (hz.StallF)     r_stall_cycles <= sat_inc(r_stall_cycles);
            if (w_flush_branch) r_flush_count <= sat_inc(r_flush_count);
        end
    end

    assign hz.mem_err      = r_mem_err;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RISC-V pipeline.
- Generates forwarding selects for the Execute stage.
- Generates stall and flush enables for the F/D/E/M/W pipeline registers.
- Arbitrates load-use, taken-branch and data-memory-wait hazards.
- Tracks memory wait time with an FSM and timeout, and keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT, 16, consecutive memory-wait cycles before mem_err is raised (must be >= 1).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
Rs1D  in  5  source register 1 of the Decode-stage instruction.
Rs2D  in  5  source register 2 of the Decode-stage instruction.
Rs1E  in  5  source register 1 of the Execute-stage instruction.
Rs2E  in  5  source register 2 of the Execute-stage instruction.
RdE  in  5  destination register in Execute.
RdM  in  5  destination register in Memory.
RdW  in  5  destination register in Writeback.
RegWriteM  in  1  Memory-stage instruction writes the register file.
RegWriteW  in  1  Writeback-stage instruction writes the register file.
ResultSrcE  in  2  result select in Execute; 2'b01 = load.
PCSrcE  in  1  taken branch/jump resolved in Execute.
MemReqM  in  1  Memory stage holds a load/store access.
MemReadyM  in  1  data memory completes the access this cycle.
ForwardAE  out  2  operand A select: 00 = regfile, 01 = W result, 10 = M ALU result.
ForwardBE  out  2  operand B select; same encoding as ForwardAE.
StallF  out  1  hold the PC register.
StallD  out  1  hold the F/D register.
StallE  out  1  hold the D/E register.
StallM  out  1  hold the E/M register.
FlushD  out  1  clear the F/D register.
FlushE  out  1  clear the D/E register.
FlushW  out  1  clear the M/W register (inject a bubble).
mem_err  out  1  sticky memory-timeout flag.
stall_cycles  out  CNT_W  number of cycles with StallF=1.
flush_count  out  CNT_W  number of cycles with FlushE caused by PCSrcE.

Behaviour:
Forwarding (combinational):
- ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Otherwise ForwardAE=00. The M stage has priority over W.
- ForwardBE follows the same rules using Rs2E.

Hazard terms (combinational):
- memStall = MemReqM && !MemReadyM.
- lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

Priority, highest first:
1. memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A branch or load-use present in the same cycle is deferred because the E and D stages are held.
2. PCSrcE (no memStall): FlushD=FlushE=1; lwStall is suppressed, so StallF=StallD=0.
3. lwStall: StallF=StallD=1, FlushE=1.
4. Otherwise: all stall and flush outputs are 0.

The pipeline registers give flush priority over stall.

FSM, states RUN and WAIT, registered:
- RUN -> WAIT when memStall. wait_cnt is loaded with 1.
- WAIT, memStall still high: wait_cnt increments and saturates at TIMEOUT.
- WAIT, memStall low: go to RUN and clear wait_cnt.
- mem_err is set on the edge where wait_cnt==TIMEOUT-1 and memStall is still 1, i.e. after TIMEOUT consecutive stall cycles.
- mem_err stays set until rst. The stall outputs keep following memStall after the timeout; there is no forced release.
- MemReadyM asserted in the same cycle as MemReqM rises gives zero stall cycles and no WAIT entry.

Counters, registered:
- stall_cycles increments every cycle StallF=1 (memStall or lwStall).
- flush_count increments every cycle PCSrcE && !memStall.
- Both saturate at 2^CNT_W-1 and never wrap.

Reset:
- Synchronous. On the edge with rst=1: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0.
- The combinational outputs depend only on the current inputs and are 0 when the hazard inputs are idle.
- Reset during WAIT returns to RUN on the next edge; a prior mem_err is cleared.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. With Rs1E=RdM=0 and RegWriteM=1 -> ForwardAE=00.
- ResultSrcE=01, RdE=3, Rs2D=3, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0; stall_cycles +1.
- Same inputs with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0; flush_count +1.
- MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all four stalls and FlushW high for 3 cycles; FSM in WAIT with wait_cnt 1,2,3; back to RUN; mem_err=0; stall_cycles=3.
- TIMEOUT=4, MemReadyM held 0 for 6 cycles -> mem_err rises after the 4th stall cycle and stays 1 after MemReadyM=1; rst pulse clears it and all counters.
- memStall and PCSrcE in the same cycle -> FlushD=FlushE=0, flush_count unchanged. Next cycle with MemReadyM=1 and PCSrcE=1 -> flush applied, flush_count +1.
